rle_decompressor: RTL and testbench
===================================

// Module: rle_decompressor
// PURPOSE
//  One decompressor lane fed by the IO FSM byte lanes (A, B or U). It expands a run-length
//  coded byte stream into fixed-width matrix/vector elements and writes them to a local
//  element memory. It signals end-of-object on eob, which drives the IO FSM finish/next logic.
//  One instance per lane; the IO FSM start bit for that lane kicks off an object.
// PARAMETERS
//  ELEM_W     8    width of one decoded element written to memory (>= 7)
//  ADDR_W     6    element memory address width
//  MAX_ELEMS  64   element capacity per object (<= 2**ADDR_W)
//  BASE_ADDR  0    memory address of the first element of every object
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         synchronous, active-low reset
//  start       in   1         1-cycle pulse: begin a new object (ignored unless IDLE)
//  in_data     in   8         compressed token byte from the IO FSM lane
//  in_valid    in   1         in_data holds a token
//  in_ready    out  1         block accepts the token this cycle
//  mem_we      out  1         element write strobe
//  mem_addr    out  ADDR_W    element write address
//  mem_data    out  ELEM_W    element write data
//  eob         out  1         1-cycle pulse: object completely decoded
//  busy        out  1         high from the start acceptance until the eob cycle inclusive
//  overflow    out  1         sticky: object exceeded MAX_ELEMS; cleared by the next accepted start
//  elem_count  out  ADDR_W+1  elements written for the current or last object
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state=IDLE; in_ready, mem_we, eob, busy, overflow=0;
//   mem_addr=BASE_ADDR; mem_data=0; elem_count=0. Reset is valid in any state and aborts the object.
//  Token format:
//   0vvvvvvv  literal: one element = v sign-extended to ELEM_W
//   1nnnnnnn  n!=0: run of n zero elements (1..127)
//   10000000  end-of-object marker
//  Handshake: a token transfers on a clk edge where in_valid && in_ready. in_ready=1 only in FETCH.
//  FSM:
//   IDLE  : start -> FETCH; clear elem_count and overflow; addr <- BASE_ADDR.
//   FETCH : literal accepted -> stay in FETCH; next cycle mem_we=1 with data=v and addr=current.
//           run n accepted -> ZRUN with remaining count = n.
//           marker accepted -> DONE.
//           in_valid=0 -> stay in FETCH and issue no write.
//   ZRUN  : in_ready=0; one zero write per cycle; remaining count decrements; at 1 -> FETCH.
//           A run of n takes exactly n cycles, then the block is back in FETCH.
//   DONE  : eob=1 and busy=1 for exactly one cycle, then IDLE. No writes.
//  Timing: all outputs are registered. A write appears 1 cycle after its literal is accepted.
//   The first zero of a run also appears 1 cycle after acceptance.
//   eob is asserted 1 cycle after the marker is accepted.
//  Each write: elem_count += 1; addr += 1, wrapping modulo 2**ADDR_W.
//  Overflow: a write that would make elem_count exceed MAX_ELEMS is suppressed (mem_we=0)
//   and sets overflow. Remaining runs are still counted down in full. Tokens are consumed
//   until the marker. eob still fires.
//  start outside IDLE (including the DONE cycle) is ignored. An in_valid token in IDLE/ZRUN/DONE
//   is not consumed.
//  Between writes mem_addr holds the next write address; mem_data holds the last written value.
// TESTING
//  1. start; tokens 05,7F,80 (one per cycle) -> writes (0,05),(1,FF); eob 1 cycle after the 80
//     is accepted; elem_count=2.
//  2. start; tokens 83,02,80 -> writes 0,0,0 at addr 0..2 on consecutive cycles, with in_ready=0
//     for 3 cycles; then (3,02); eob; elem_count=4.
//  3. in_valid toggled 1/0 around tokens 01,02,80 -> only accepted tokens are written; no
//     duplicates; order is preserved.
//  4. MAX_ELEMS=64; start; tokens C2 (66 zeros),80 -> 64 writes; overflow=1; eob; elem_count=64.
//     The next start clears overflow.
//  5. reset=0 in the middle of a ZRUN -> next cycle IDLE, all outputs at reset values, no further
//     writes. A start pulse during busy does not restart the object.
//  6. Back-to-back objects: a start in the cycle right after eob -> second object again begins
//     at BASE_ADDR; a start in the eob cycle is ignored.

Source files
------------

// File: rtl/rle_decompressor.sv
// Run-length decoder lane: expands literal/zero-run tokens into ELEM_W-wide elements
// and streams them to a local element memory, pulsing eob_o when the end marker is consumed.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for start_i; outputs hold the last object's results
//   S_FETCH | in_ready_o high; consume literal / run / end-marker tokens
//   S_ZRUN  | emitting one zero element per cycle until the run is exhausted
//   S_DONE  | single cycle with eob_o high, then back to S_IDLE
module rle_decompressor #(
    parameter int ELEM_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int MAX_ELEMS = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ELEM_W-1:0] mem_data_o,
    output logic              eob_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   elem_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ZRUN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_ELEMS);

    state_t              state_q, state_d;
    logic [6:0]          run_q, run_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ELEM_W-1:0]   data_q, data_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                we_q, we_d;
    logic                ovf_q, ovf_d;
    logic                ready_q, ready_d;
    logic                eob_q, eob_d;
    logic                busy_q, busy_d;

    logic                wr_req;
    logic [ELEM_W-1:0]   wr_val;
    logic [ELEM_W-1:0]   lit_val;
    logic                accept;

    assign lit_val = ELEM_W'($signed(in_data_i[6:0]));
    assign accept  = in_valid_i && ready_q;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        we_d    = 1'b0;
        wr_req  = 1'b0;
        wr_val  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    ptr_d   = BASE;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    if (!in_data_i[7]) begin
                        wr_req = 1'b1;
                        wr_val = lit_val;
                    end else if (in_data_i[6:0] == 7'd0) begin
                        state_d = S_DONE;
                    end else begin
                        // First zero of the run is issued on the accepting edge.
                        state_d = S_ZRUN;
                        run_d   = in_data_i[6:0];
                        wr_req  = 1'b1;
                    end
                end
            end
            S_ZRUN: begin
                if (run_q == 7'd1) begin
                    state_d = S_FETCH;
                end else begin
                    run_d  = run_q - 7'd1;
                    wr_req = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Writes beyond capacity are dropped but still flagged.
        if (wr_req) begin
            if (count_q >= MAX_CNT) begin
                ovf_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                data_d  = wr_val;
                count_d = count_q + 1'b1;
                ptr_d   = ptr_q + 1'b1;
            end
        end

        addr_d  = we_d ? ptr_q : ptr_d;
        ready_d = (state_d == S_FETCH);
        eob_d   = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            ptr_q   <= BASE;
            addr_q  <= BASE;
            data_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            eob_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            eob_q   <= eob_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready_o   = ready_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign eob_o        = eob_q;
    assign busy_o       = busy_q;
    assign overflow_o   = ovf_q;
    assign elem_count_o = count_q;

endmodule

// File: tb/tb_rle_decompressor.sv
// Bench for rle_decompressor: directed scenarios plus random token streams, each object
// checked against a list-of-writes reference computed directly from the token rules.
module tb_rle_decompressor;

    localparam int ELEM_W    = 8;
    localparam int ADDR_W    = 6;
    localparam int MAX_ELEMS = 64;
    localparam int BASE_ADDR = 0;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic              start_i;
    logic [7:0]        in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [ELEM_W-1:0] mem_data_o;
    logic              eob_o;
    logic              busy_o;
    logic              overflow_o;
    logic [ADDR_W:0]   elem_count_o;

    rle_decompressor #(
        .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .MAX_ELEMS(MAX_ELEMS), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .eob_o(eob_o), .busy_o(busy_o), .overflow_o(overflow_o), .elem_count_o(elem_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;

    logic [7:0]  tok_q[$];
    logic [13:0] exp_q[$];
    logic [13:0] got_q[$];
    int          exp_cnt;
    int          exp_addr;
    bit          exp_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (mem_we_o === 1'b1) begin
            got_q.push_back({mem_addr_o, mem_data_o});
            n_wr++;
        end
    end

    // Reference: walk the token list and emit the element list it describes.
    task automatic model();
        int a;
        int cnt;
        logic [7:0] t;
        logic [ELEM_W-1:0] v;
        logic [ADDR_W-1:0] a6;
        exp_q.delete();
        exp_ovf = 1'b0;
        a   = BASE_ADDR;
        cnt = 0;
        foreach (tok_q[i]) begin
            t = tok_q[i];
            if (t == 8'h80) break;
            for (int k = 0; k < (t[7] ? int'(t[6:0]) : 1); k++) begin
                v = t[7] ? '0 : {t[6], t[6:0]};
                if (cnt < MAX_ELEMS) begin
                    a6 = ADDR_W'(a);
                    exp_q.push_back({a6, v});
                    a = (a + 1) % (1 << ADDR_W);
                    cnt++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        exp_cnt  = cnt;
        exp_addr = a;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge one cycle after eob.
    task automatic run_obj(input bit gaps, input bit eob_start);
        int  wait_cyc;
        int  stall;
        bit  acc;
        logic [7:0] t;
        model();
        got_q.delete();
        start_i    = 1'b1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_busy", 32'(busy_o), 1);
        chk("start_ready", 32'(in_ready_o), 1);
        chk("start_count", 32'(elem_count_o), 0);
        chk("start_ovf", 32'(overflow_o), 0);
        chk("start_addr", 32'(mem_addr_o), BASE_ADDR);
        foreach (tok_q[i]) begin
            t = tok_q[i];
            acc = 1'b0;
            wait_cyc = 0;
            while (!acc) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    in_valid_i = 1'b0;
                    in_data_i  = 8'($urandom);
                end else begin
                    in_valid_i = 1'b1;
                    in_data_i  = t;
                end
                start_i = ($urandom_range(0, 9) == 0);
                acc = in_valid_i && in_ready_o;
                @(negedge clk_i);
                wait_cyc++;
                if (!acc && wait_cyc > 200) begin
                    chk("accept_timeout", 0, 1);
                    in_valid_i = 1'b0;
                    start_i    = 1'b0;
                    return;
                end
            end
            in_valid_i = 1'b0;
            start_i    = 1'b0;
            if (t[7] && t[6:0] != 7'd0) begin
                stall = 0;
                while (!in_ready_o && stall < 200) begin
                    in_valid_i = 1'($urandom_range(0, 1));
                    in_data_i  = 8'($urandom);
                    @(negedge clk_i);
                    stall++;
                end
                in_valid_i = 1'b0;
                chk("run_stall_cycles", 32'(stall), 32'(t[6:0]));
            end else if (!t[7]) begin
                chk("literal_ready", 32'(in_ready_o), 1);
            end
        end
        chk("eob_pulse", 32'(eob_o), 1);
        chk("eob_busy", 32'(busy_o), 1);
        chk("eob_ready", 32'(in_ready_o), 0);
        chk("eob_count", 32'(elem_count_o), 32'(exp_cnt));
        chk("eob_ovf", 32'(overflow_o), 32'(exp_ovf));
        chk("eob_next_addr", 32'(mem_addr_o), 32'(exp_addr));
        if (exp_q.size() > 0) chk("eob_last_data", 32'(mem_data_o), 32'(exp_q[$][ELEM_W-1:0]));
        if (eob_start) start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("post_eob", 32'(eob_o), 0);
        chk("post_busy", 32'(busy_o), 0);
        chk("write_total", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("write[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready_o), 0);
        chk({tag, "_we"}, 32'(mem_we_o), 0);
        chk({tag, "_eob"}, 32'(eob_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_ovf"}, 32'(overflow_o), 0);
        chk({tag, "_addr"}, 32'(mem_addr_o), BASE_ADDR);
        chk({tag, "_data"}, 32'(mem_data_o), 0);
        chk({tag, "_count"}, 32'(elem_count_o), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_snap;
        reset_ni   = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = 8'h00;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        reset_ni = 1'b1;

        // Tokens offered while idle must not be consumed.
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'($urandom_range(0, 127));
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        chk("idle_no_writes", 32'(n_wr), 0);
        chk("idle_ready", 32'(in_ready_o), 0);

        tok_q = '{8'h05, 8'h7F, 8'h80};
        run_obj(1'b0, 1'b0);
        tok_q = '{8'h83, 8'h02, 8'h80};
        run_obj(1'b0, 1'b0);
        tok_q = '{8'h01, 8'h02, 8'h80};
        run_obj(1'b1, 1'b0);
        tok_q = '{8'hC2, 8'h80};
        run_obj(1'b0, 1'b1);
        tok_q = '{8'h04, 8'h80};
        run_obj(1'b0, 1'b0);

        // Reset in the middle of a zero run, with a stray start while busy.
        got_q.delete();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 8'h90;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("zrun_we0", 32'(mem_we_o), 1);
        chk("zrun_addr0", 32'(mem_addr_o), BASE_ADDR);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("zrun_addr1", 32'(mem_addr_o), BASE_ADDR + 1);
        @(negedge clk_i);
        chk("zrun_addr2", 32'(mem_addr_o), BASE_ADDR + 2);
        chk("zrun_busy", 32'(busy_o), 1);
        reset_ni = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        check_reset_outputs("midrun_reset");
        wr_snap = n_wr;
        repeat (4) @(negedge clk_i);
        chk("after_reset_writes", 32'(n_wr - wr_snap), 0);
        chk("after_reset_busy", 32'(busy_o), 0);

        // Back-to-back objects, with and without a start in the eob cycle.
        tok_q = '{8'h11, 8'h81, 8'h80};
        run_obj(1'b0, 1'b1);
        tok_q = '{8'h40, 8'h80};
        run_obj(1'b0, 1'b0);

        for (int obj = 0; obj < 25; obj++) begin
            int ntok;
            logic [6:0] r7;
            tok_q.delete();
            ntok = $urandom_range(1, 7);
            for (int i = 0; i < ntok; i++) begin
                if ($urandom_range(0, 9) < 6) begin
                    r7 = 7'($urandom);
                    tok_q.push_back({1'b0, r7});
                end else begin
                    r7 = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(20, 100))
                                                     : 7'($urandom_range(1, 10));
                    tok_q.push_back({1'b1, r7});
                end
            end
            tok_q.push_back(8'h80);
            run_obj(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
